// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed by a byte FIFO. Upstream pushes bytes whenever the
//   FIFO has room. The serialiser sends them back to back, with no idle time
//   between frames. The frame format is fixed at elaboration by parameters.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   Wr_En        push Wr_Data into the FIFO (dropped when Full)
//   Wr_Data[7:0] byte to send; bits above DATA_BITS-1 are ignored
//   Full         FIFO holds FIFO_DEPTH entries
//   Empty        FIFO holds no entries
//   Level        FIFO occupancy, 0..FIFO_DEPTH
//   Overflow     sticky: a write was dropped; cleared only by RST
//   Tx_Busy      serialiser is in a frame
//   Tx_Done_Sig  high during the last cycle of each frame's final stop bit
//   Tx_Pin_Out   registered serial line, idles high
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Wr_En,
    input  logic [7:0]        Wr_Data,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Level,
    output logic              Overflow,
    output logic              Tx_Busy,
    output logic              Tx_Done_Sig,
    output logic              Tx_Pin_Out
);

    localparam int                 TIMER_W   = $clog2(BAUD_DIV);
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(BAUD_DIV - 1);
    localparam logic [7:0]         DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]         IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- FIFO ----------------
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              push, pop;

    assign Full  = (Level == (ADDR_W+1)'(FIFO_DEPTH));
    assign Empty = (Level == '0);
    // Full is the registered occupancy, so a write that lands on the same
    // edge as a pop from a full FIFO is still dropped.
    assign push  = Wr_En && !Full;

    // NOTE: the storage array has no reset; the pointers and Level alone
    // decide which entries are valid, so stale data is never observable.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= Wr_Data;
    end

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Level    <= '0;
            Overflow <= 1'b0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push && !pop)      Level <= Level + (ADDR_W+1)'(1);
            else if (pop && !push) Level <= Level - (ADDR_W+1)'(1);
            if (Wr_En && Full) Overflow <= 1'b1;
        end
    end

    // ---------------- serialiser ----------------
    state_t             state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [2:0]         bit_idx, idx_n;
    logic               stop_idx, stop_n;
    logic [7:0]         shift, shift_n;
    logic               par_bit, par_n;
    logic               line_n;
    logic               bit_end;
    logic               start_frame;
    logic [7:0]         head_byte;
    logic               head_par;

    assign bit_end   = (timer == BIT_LAST);
    assign head_byte = mem[rd_ptr] & DATA_MASK;
    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign head_par  = (^head_byte) ^ (PARITY == 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            par_bit    <= 1'b0;
            Tx_Pin_Out <= 1'b1;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_idx    <= idx_n;
            stop_idx   <= stop_n;
            shift      <= shift_n;
            par_bit    <= par_n;
            Tx_Pin_Out <= line_n;
        end
    end

    // The line value is computed for the state being entered and registered,
    // so Tx_Pin_Out changes exactly on bit boundaries with no decode glitches.
    // NOTE: every signal gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        idx_n       = bit_idx;
        stop_n      = stop_idx;
        shift_n     = shift;
        par_n       = par_bit;
        line_n      = Tx_Pin_Out;
        pop         = 1'b0;
        start_frame = 1'b0;

        if (state != S_IDLE) timer_n = bit_end ? '0 : timer + TIMER_W'(1);

        case (state)
            S_IDLE: begin
                line_n      = 1'b1;
                timer_n     = '0;
                start_frame = !Empty;
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    idx_n   = '0;
                    line_n  = shift[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_n = S_PAR;
                            line_n  = par_bit;
                        end else begin
                            state_n = S_STOP;
                            stop_n  = 1'b0;
                            line_n  = 1'b1;
                        end
                    end else begin
                        idx_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        line_n  = shift[1];
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    stop_n  = 1'b0;
                    line_n  = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        // Chain straight into the next start bit when data
                        // is waiting, so frames stay contiguous.
                        state_n     = S_IDLE;
                        line_n      = 1'b1;
                        start_frame = !Empty;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                line_n  = 1'b1;
            end
        endcase

        if (start_frame) begin
            pop     = 1'b1;
            shift_n = head_byte;
            par_n   = head_par;
            state_n = S_START;
            timer_n = '0;
            line_n  = 1'b0;
        end
    end

    assign Tx_Busy     = (state != S_IDLE);
    assign Tx_Done_Sig = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Five instances with different frame formats
// share one clock and reset. Each cycle, every output is compared against a
// frame-level reference model. The model keeps a byte queue and a cycle
// position within the current frame.
module tb_uart_tx_fifo;

    localparam int N = 5;

    // Per-instance format: 8N1, 8E1, 8O1, 7N2 (all BAUD 4, depth 16), 6O2 (BAUD 3, depth 4)
    int p_baud  [N] = '{4, 4, 4, 4, 3};
    int p_db    [N] = '{8, 8, 8, 7, 6};
    int p_par   [N] = '{0, 2, 1, 0, 1};
    int p_stop  [N] = '{1, 1, 1, 2, 2};
    int p_depth [N] = '{16, 16, 16, 16, 4};

    logic       CLK = 1'b0;
    logic       RST;
    logic       wr_en   [N];
    logic [7:0] wr_data [N];
    logic       full [N], empty [N], ovf [N], busy [N], done [N], pin [N];
    logic [4:0] lvl_a [4];
    logic [2:0] lvl4;

    always #5 CLK = ~CLK;

    uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16), .ADDR_W(4)) u0 (
        .CLK(CLK), .RST(RST), .Wr_En(wr_en[0]), .Wr_Data(wr_data[0]), .Full(full[0]), .Empty(empty[0]),
        .Level(lvl_a[0]), .Overflow(ovf[0]), .Tx_Busy(busy[0]), .Tx_Done_Sig(done[0]), .Tx_Pin_Out(pin[0]));
    uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16), .ADDR_W(4)) u1 (
        .CLK(CLK), .RST(RST), .Wr_En(wr_en[1]), .Wr_Data(wr_data[1]), .Full(full[1]), .Empty(empty[1]),
        .Level(lvl_a[1]), .Overflow(ovf[1]), .Tx_Busy(busy[1]), .Tx_Done_Sig(done[1]), .Tx_Pin_Out(pin[1]));
    uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16), .ADDR_W(4)) u2 (
        .CLK(CLK), .RST(RST), .Wr_En(wr_en[2]), .Wr_Data(wr_data[2]), .Full(full[2]), .Empty(empty[2]),
        .Level(lvl_a[2]), .Overflow(ovf[2]), .Tx_Busy(busy[2]), .Tx_Done_Sig(done[2]), .Tx_Pin_Out(pin[2]));
    uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16), .ADDR_W(4)) u3 (
        .CLK(CLK), .RST(RST), .Wr_En(wr_en[3]), .Wr_Data(wr_data[3]), .Full(full[3]), .Empty(empty[3]),
        .Level(lvl_a[3]), .Overflow(ovf[3]), .Tx_Busy(busy[3]), .Tx_Done_Sig(done[3]), .Tx_Pin_Out(pin[3]));
    uart_tx_fifo #(.BAUD_DIV(3), .DATA_BITS(6), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .ADDR_W(2)) u4 (
        .CLK(CLK), .RST(RST), .Wr_En(wr_en[4]), .Wr_Data(wr_data[4]), .Full(full[4]), .Empty(empty[4]),
        .Level(lvl4), .Overflow(ovf[4]), .Tx_Busy(busy[4]), .Tx_Done_Sig(done[4]), .Tx_Pin_Out(pin[4]));

    // ---------------- reference model ----------------
    bit         m_busy [N];
    bit         m_ovf  [N];
    int         m_cyc  [N];   // cycle position inside the current frame
    int         m_cnt  [N];
    int         m_head [N];
    logic [7:0] m_cur  [N];
    logic [7:0] m_mem  [N][16];

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    int   start_cyc [N];
    int   done_cyc  [N];
    int   done_cnt  [N];
    logic par_smp   [N];
    bit   prev_busy [N];
    int   d_times   [4];
    int   d_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic int flen(int i);
        return (1 + p_db[i] + ((p_par[i] != 0) ? 1 : 0) + p_stop[i]) * p_baud[i];
    endfunction

    function automatic logic [4:0] lvl_of(int i);
        if (i < 4) return lvl_a[i];
        return {2'b00, lvl4};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_cyc[i]  = 0;
            m_cnt[i]  = 0;
            m_head[i] = 0;
            m_cur[i]  = '0;
        end
    endfunction

    // Advances the model by one rising edge, using the inputs that were
    // applied before the edge.
    function automatic void model_step();
        for (int i = 0; i < N; i++) begin
            int         pre_cnt;
            int         tail;
            bit         do_pop;
            bit         acc;
            logic [7:0] popped;
            logic [7:0] mask;
            if (RST) begin
                m_busy[i] = 1'b0; m_ovf[i] = 1'b0; m_cyc[i] = 0;
                m_cnt[i] = 0; m_head[i] = 0;
                continue;
            end
            pre_cnt = m_cnt[i];
            tail    = (m_head[i] + pre_cnt) % p_depth[i];
            do_pop  = (pre_cnt > 0) && (!m_busy[i] || m_cyc[i] == flen(i) - 1);
            acc     = wr_en[i] && (pre_cnt < p_depth[i]);
            if (wr_en[i] && pre_cnt == p_depth[i]) m_ovf[i] = 1'b1;
            popped  = m_mem[i][m_head[i]];
            if (do_pop) begin
                m_head[i] = (m_head[i] + 1) % p_depth[i];
                m_cnt[i]--;
            end
            if (acc) begin
                m_mem[i][tail] = wr_data[i];
                m_cnt[i]++;
            end
            if (do_pop) begin
                mask      = 8'((1 << p_db[i]) - 1);
                m_busy[i] = 1'b1;
                m_cyc[i]  = 0;
                m_cur[i]  = popped & mask;
            end else if (m_busy[i]) begin
                if (m_cyc[i] == flen(i) - 1) m_busy[i] = 1'b0;
                else m_cyc[i]++;
            end
        end
    endfunction

    function automatic logic exp_pin(int i);
        int k;
        if (!m_busy[i]) return 1'b1;
        k = m_cyc[i] / p_baud[i];
        if (k == 0) return 1'b0;
        if (k <= p_db[i]) return m_cur[i][k-1];
        if (p_par[i] != 0 && k == p_db[i] + 1)
            return (p_par[i] == 2) ? ^m_cur[i] : ~^m_cur[i];
        return 1'b1;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("pin[%0d]", i),   pin[i],   exp_pin(i));
            check($sformatf("busy[%0d]", i),  busy[i],  m_busy[i]);
            check($sformatf("done[%0d]", i),  done[i],  m_busy[i] && m_cyc[i] == flen(i) - 1);
            check($sformatf("level[%0d]", i), lvl_of(i), m_cnt[i]);
            check($sformatf("empty[%0d]", i), empty[i], m_cnt[i] == 0);
            check($sformatf("full[%0d]", i),  full[i],  m_cnt[i] == p_depth[i]);
            check($sformatf("ovf[%0d]", i),   ovf[i],   m_ovf[i]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        cyc_n++;
        #1;
        compare_all();
        for (int i = 0; i < N; i++) begin
            if (busy[i] && !prev_busy[i]) start_cyc[i] = cyc_n;
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc_n;
                if (i == 0 && d_n < 4) begin
                    d_times[d_n] = cyc_n;
                    d_n++;
                end
            end
            if (p_par[i] != 0 && m_busy[i] && m_cyc[i] == (1 + p_db[i]) * p_baud[i] + 1)
                par_smp[i] = pin[i];
            prev_busy[i] = busy[i];
        end
    endtask

    task automatic drain(input int budget);
        int  k = 0;
        bit  active = 1'b1;
        while (active && k < budget) begin
            tick();
            k++;
            active = 1'b0;
            for (int i = 0; i < N; i++)
                if (m_busy[i] || m_cnt[i] != 0 || busy[i]) active = 1'b1;
        end
        if (active) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        d_n = 0;
    endtask

    initial begin
        RST = 1'b1;
        for (int i = 0; i < N; i++) begin
            wr_en[i] = 1'b0; wr_data[i] = '0;
            start_cyc[i] = 0; done_cyc[i] = 0; done_cnt[i] = 0;
            par_smp[i] = 1'bx; prev_busy[i] = 1'b0;
        end
        d_n = 0;
        model_reset();
        #1;
        compare_all();                 // reset state
        tick(); tick();
        RST = 1'b0;
        tick();

        // Single frame on every format: 0x2E / 0x07 / 0x07 / 0xFF / 0x2E
        clear_counts();
        wr_data[0] = 8'h2E; wr_data[1] = 8'h07; wr_data[2] = 8'h07;
        wr_data[3] = 8'hFF; wr_data[4] = 8'h2E;
        for (int i = 0; i < N; i++) wr_en[i] = 1'b1;
        tick();
        for (int i = 0; i < N; i++) wr_en[i] = 1'b0;
        drain(200);
        tick();
        check("single_done_cnt", done_cnt[0], 1);
        check("len_8n1", done_cyc[0] - start_cyc[0] + 1, 40);
        check("len_8e1", done_cyc[1] - start_cyc[1] + 1, 44);
        check("len_8o1", done_cyc[2] - start_cyc[2] + 1, 44);
        check("len_7n2", done_cyc[3] - start_cyc[3] + 1, 40);
        check("len_6o2", done_cyc[4] - start_cyc[4] + 1, 30);
        check("par_even_07", par_smp[1], 1'b1);
        check("par_odd_07",  par_smp[2], 1'b0);
        check("busy_after_single", busy[0], 1'b0);

        // Parity with 0x3F
        wr_data[1] = 8'h3F; wr_data[2] = 8'h3F;
        wr_en[1] = 1'b1; wr_en[2] = 1'b1;
        tick();
        wr_en[1] = 1'b0; wr_en[2] = 1'b0;
        drain(200);
        check("par_even_3f", par_smp[1], 1'b0);
        check("par_odd_3f",  par_smp[2], 1'b1);

        // Back-to-back on 8N1
        clear_counts();
        wr_en[0] = 1'b1;
        wr_data[0] = 8'h2E; tick();
        wr_data[0] = 8'h3F; tick();
        wr_data[0] = 8'hDD; tick();
        wr_en[0] = 1'b0;
        check("b2b_level", lvl_of(0), 2);
        drain(400);
        check("b2b_done_cnt", d_n, 3);
        check("b2b_gap1", d_times[1] - d_times[0], 40);
        check("b2b_gap2", d_times[2] - d_times[1], 40);

        // Overflow on 8N1: 18 consecutive writes from IDLE
        clear_counts();
        wr_en[0] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            wr_data[0] = 8'(8'h40 + k);
            tick();
            if (k == 16) begin
                check("ovf_level16", lvl_of(0), 16);
                check("ovf_full", full[0], 1'b1);
                check("ovf_not_yet", ovf[0], 1'b0);
            end
        end
        wr_en[0] = 1'b0;
        check("ovf_set", ovf[0], 1'b1);
        check("ovf_level_kept", lvl_of(0), 16);
        drain(1000);
        check("ovf_frames", done_cnt[0], 17);
        check("ovf_sticky", ovf[0], 1'b1);

        // Reset during data bit 3 with two bytes queued
        wr_en[0] = 1'b1;
        wr_data[0] = 8'h11; tick();
        wr_data[0] = 8'h22; tick();
        wr_data[0] = 8'h33; tick();
        wr_en[0] = 1'b0;
        for (int k = 0; k < 100 && !(m_busy[0] && m_cyc[0] == 17); k++) tick();
        check("rst_reached_bit3", m_cyc[0], 17);
        RST = 1'b1;
        #1;
        check("rst_pin",   pin[0], 1'b1);
        check("rst_level", lvl_of(0), 0);
        check("rst_empty", empty[0], 1'b1);
        check("rst_busy",  busy[0], 1'b0);
        check("rst_done",  done[0], 1'b0);
        check("rst_ovf",   ovf[0], 1'b0);
        model_reset();
        tick(); tick();
        RST = 1'b0;
        clear_counts();
        for (int k = 0; k < 60; k++) tick();
        check("rst_quiet", done_cnt[0], 0);
        wr_en[0] = 1'b1; wr_data[0] = 8'hA5; tick(); wr_en[0] = 1'b0;
        drain(200);
        check("rst_resume", done_cnt[0], 1);

        // Randomised traffic at three write densities, with one reset inside
        for (int ph = 0; ph < 3; ph++) begin
            int rate;
            rate = (ph == 0) ? 5 : (ph == 1) ? 30 : 95;
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < N; i++) begin
                    wr_en[i]   = ($urandom_range(0, 99) < rate);
                    wr_data[i] = 8'($urandom);
                end
                if (ph == 1 && c == 700) RST = 1'b1;
                tick();
                RST = 1'b0;
            end
            for (int i = 0; i < N; i++) wr_en[i] = 1'b0;
            drain(3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated byte FIFO and configurable frame format. It replaces the single-byte "assert enable, wait for done" handshake: upstream logic pushes bytes whenever the FIFO has room, and the block serialises them onto one line with no inter-frame gaps. It sits between any byte producer (command sequencer, debug logger) and the board TX pin.

## Interface

Parameters:
- BAUD_DIV, 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 2 or more.
- DATA_BITS, 8: data bits per frame, 5 to 8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries. Must be a power of 2.
- ADDR_W, 4: log2(FIFO_DEPTH).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- Wr_En  in  1  push Wr_Data into the FIFO.
- Wr_Data  in  8  byte to send. Bits [7:DATA_BITS] are ignored.
- Full  out  1  FIFO holds FIFO_DEPTH entries.
- Empty  out  1  FIFO holds 0 entries.
- Level  out  ADDR_W+1  current FIFO occupancy.
- Overflow  out  1  sticky flag: a write was dropped. Cleared only by RST.
- Tx_Busy  out  1  FSM is not in IDLE.
- Tx_Done_Sig  out  1  one-cycle pulse at the end of each frame.
- Tx_Pin_Out  out  1  serial line; idles high.

## Operation

FIFO:
- A write is accepted when Wr_En=1 and Full=0. Full is the registered value.
- A write with Full=1 is dropped and sets Overflow.
- A pop happens only when the FSM loads a frame.
- Level changes per cycle:
  - write only: +1
  - pop only: -1
  - write and pop together: unchanged
- Full and Empty are derived from Level.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: Tx_Pin_Out=1. If Empty=0, pop the FIFO head into the shift register, clear the bit timer, and go to START.
- START: line = 0 for BAUD_DIV cycles, then go to DATA.
- DATA: shift out DATA_BITS bits, LSB first, BAUD_DIV cycles each.
  - Go to PAR if PARITY≠0, otherwise go to STOP.
- PAR: line = XOR of the data bits for even parity, or its inverse for odd parity. Lasts BAUD_DIV cycles.
- STOP: line = 1 for STOP_BITS×BAUD_DIV cycles. In the last cycle of the final stop bit, Tx_Done_Sig=1, then:
  - if Empty=0: pop the next byte and go directly to START, giving a contiguous frame;
  - otherwise go to IDLE.
- Bit timer: counts 0..BAUD_DIV-1 and wraps at each bit boundary.
- Bit index: counts 0..DATA_BITS-1.
- Tx_Pin_Out is registered and glitch-free.

Reset, asynchronous and also mid-frame:
- Tx_Pin_Out=1
- Tx_Busy=0, Tx_Done_Sig=0
- Empty=1, Full=0, Level=0, Overflow=0
- FSM returns to IDLE and FIFO contents are discarded.
- Transmission resumes only after a new write.

## Timing

- Frame length: F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles, exactly.
- Latency from IDLE: a write accepted at edge n makes Empty=0 after edge n. The pop occurs at edge n+1, and Tx_Pin_Out falls after edge n+1.
- Tx_Busy rises together with the start bit and falls at the edge where the FSM enters IDLE.
- Back-to-back frames: successive start bits are exactly F cycles apart, and Tx_Done_Sig pulses are F cycles apart.
- Tx_Done_Sig is high for exactly one cycle per frame, coincident with the last stop-bit cycle.
- A write into a full FIFO on the same edge as a pop is dropped, because Full is the registered value.

## Test plan

- **Single byte, 8N1, BAUD_DIV=4.** Write 0x2E. Line after the write+1 edge, each level held 4 cycles: 0 | 0,1,1,1,0,1,0,0 | 1. Tx_Done_Sig pulses once, 40 cycles after the start bit begins. Tx_Busy then drops.
- **Parity, 8E1 and 8O1.**
  - Write 0x07: parity bit is 1 for even, 0 for odd.
  - Write 0x3F: parity bit is 0 for even, 1 for odd.
  - Frame length is 44 cycles with BAUD_DIV=4.
- **Back-to-back.** Write 0x2E, 0x3F, 0xDD on three consecutive edges. Expect three contiguous frames with no idle cycles between stop and start, and three Tx_Done_Sig pulses spaced exactly 40 cycles apart. Level goes to 1, then 2, then falls as each byte is popped.
- **Overflow, FIFO_DEPTH=16.** Starting from IDLE, write on 18 consecutive cycles. The first write is popped at the next edge. Expect:
  - Level reaches 16 and Full=1 after the 17th write;
  - the 18th write is dropped and Overflow=1 (stays set);
  - 17 frames are transmitted with the bytes in order.
- **Format 7 data bits, 2 stop bits, no parity, BAUD_DIV=4.** Write 0xFF. Expect 7 data ones, with bit 7 ignored, and a stop high of 8 cycles. Done pulses at cycle 40.
- **Reset mid-frame.** Assert RST during data bit 3 with 2 bytes queued. Expect Tx_Pin_Out=1 immediately, asynchronously, with Level=0, Empty=1, Tx_Busy=0. No further frames are sent until a new write, which then transmits normally.
